// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared trap_sel codes, FSM states and defaults for trap_ctrl
package trap_ctrl_pkg;

   // trap_sel values line up with the core's PCSrc encoding
   typedef enum logic [2:0] {
      TRAP_NONE = 3'h0,
      TRAP_IRQ  = 3'h4,
      TRAP_EXC  = 3'h5
   } trap_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_TRAP    = 2'd2,
      ST_HANDLER = 2'd3
   } trap_state_e;

   localparam int IRQ_BASE_DEFAULT = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// rtl/trap_ctrl_irq_prio_enc.sv - lowest-index-wins priority encoder over pending irqs
module irq_prio_enc #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - interrupt/exception controller: pending latches, arbitration,
// pipeline-safe trap redirect and EPC/cause capture
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int                 NUM_IRQ   = 8,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = NUM_IRQ'(8'h01),
   parameter int                 CAUSE_W   = 5,
   parameter logic [CAUSE_W-1:0] IRQ_BASE  = CAUSE_W'(IRQ_BASE_DEFAULT)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_src,
   input  logic               kernel_mode,
   input  logic               id_valid,
   input  logic [31:0]        id_pc,
   input  logic               exc_valid,
   input  logic [CAUSE_W-1:0] exc_code,
   input  logic               pipe_ready,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wdata,
   input  logic               eret,
   output logic               trap_take,
   output logic [2:0]         trap_sel,
   output logic               flush,
   output logic [31:0]        epc,
   output logic [CAUSE_W-1:0] cause,
   output logic [NUM_IRQ-1:0] pending,
   output logic               in_trap
);

   localparam int IDX_W = idx_width(NUM_IRQ);

   logic [NUM_IRQ-1:0] lat_q, lat_d;
   logic [NUM_IRQ-1:0] prev_q, prev_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   trap_state_e        state_q, state_d;
   logic               snap_exc_q, snap_exc_d;
   logic [31:0]        epc_q, epc_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic               trap_take_q, trap_take_d;
   trap_sel_e          trap_sel_q, trap_sel_d;
   logic               in_trap_q, in_trap_d;

   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;
   logic               irq_valid;
   logic [IDX_W-1:0]   irq_idx;
   logic               exc_now;
   logic               irq_now;
   logic               req_now;
   logic [CAUSE_W-1:0] sel_code;

   assign pend = lat_q & mask_q;

   irq_prio_enc #(
      .N     (NUM_IRQ),
      .IDX_W (IDX_W)
   ) u_prio (
      .req   (pend),
      .valid (irq_valid),
      .idx   (irq_idx)
   );

   // Traps are only requested against a real user-mode instruction in ID
   assign exc_now  = exc_valid & id_valid & ~kernel_mode;
   assign irq_now  = irq_valid & id_valid & ~kernel_mode;
   assign req_now  = exc_now | irq_now;
   assign sel_code = exc_now ? exc_code : (IRQ_BASE + CAUSE_W'(irq_idx));
   assign rise     = irq_src & ~prev_q;

   always_comb begin
      state_d     = state_q;
      snap_exc_d  = snap_exc_q;
      epc_d       = epc_q;
      cause_d     = cause_q;
      trap_take_d = 1'b0;
      trap_sel_d  = TRAP_NONE;
      in_trap_d   = 1'b0;
      clr         = '0;
      prev_d      = irq_src;
      mask_d      = mask_we ? mask_wdata : mask_q;

      case (state_q)
         ST_IDLE: begin
            if (req_now) begin
               state_d    = ST_WAIT;
               snap_exc_d = exc_now;
            end
         end
         ST_WAIT: begin
            // A vanished exception means ID moved on; the snapshot is stale
            if ((snap_exc_q && !exc_now) || !req_now) begin
               state_d = ST_IDLE;
            end else if (pipe_ready) begin
               state_d     = ST_TRAP;
               trap_take_d = 1'b1;
               trap_sel_d  = exc_now ? TRAP_EXC : TRAP_IRQ;
               epc_d       = id_pc;
               cause_d     = sel_code;
               if (!exc_now) clr = NUM_IRQ'(1) << irq_idx;
            end else begin
               snap_exc_d = exc_now;
            end
         end
         ST_TRAP: begin
            state_d   = ST_HANDLER;
            in_trap_d = 1'b1;
         end
         ST_HANDLER: begin
            if (eret) state_d = ST_IDLE;
            else      in_trap_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // A fresh edge wins over the clear so a back-to-back event is not lost
      lat_d = (EDGE_MASK & ((lat_q & ~clr) | rise)) | (~EDGE_MASK & irq_src);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_q       <= '0;
         prev_q      <= '0;
         mask_q      <= '1;
         state_q     <= ST_IDLE;
         snap_exc_q  <= 1'b0;
         epc_q       <= '0;
         cause_q     <= '0;
         trap_take_q <= 1'b0;
         trap_sel_q  <= TRAP_NONE;
         in_trap_q   <= 1'b0;
      end else begin
         lat_q       <= lat_d;
         prev_q      <= prev_d;
         mask_q      <= mask_d;
         state_q     <= state_d;
         snap_exc_q  <= snap_exc_d;
         epc_q       <= epc_d;
         cause_q     <= cause_d;
         trap_take_q <= trap_take_d;
         trap_sel_q  <= trap_sel_d;
         in_trap_q   <= in_trap_d;
      end
   end

   assign trap_take = trap_take_q;
   assign flush     = trap_take_q;
   assign trap_sel  = trap_sel_q;
   assign epc       = epc_q;
   assign cause     = cause_q;
   assign pending   = pend;
   assign in_trap   = in_trap_q;

endmodule
